// File: rtl/tap_comb_pkg.sv
// Shared widths, depths and arithmetic helpers for the tap combiner.
package tap_comb_pkg;

   localparam int TAP_W      = 8;
   localparam int COEF_W     = 8;
   localparam int PROD_W     = 16;
   localparam int SUM_W      = 18;
   localparam int FILL_DEPTH = 64;
   localparam int FILL_W     = 7;
   localparam int FIFO_DEPTH = 2;
   localparam int CNT_W      = 16;

   typedef logic signed [PROD_W-1:0] prod_t;
   typedef logic signed [SUM_W-1:0]  sum_t;

   // Zero-extended unsigned tap times signed coefficient. The extremes
   // (255 * -128 and 255 * 127) fit in 16 signed bits, so the top
   // product bit can be dropped without loss.
   function automatic prod_t tap_mul(input logic [TAP_W-1:0] tap,
                                     input logic signed [COEF_W-1:0] coef);
      logic signed [TAP_W:0]        w_tap;
      logic signed [TAP_W+COEF_W:0] w_full;
      w_tap  = {1'b0, tap};
      w_full = w_tap * coef;
      return w_full[PROD_W-1:0];
   endfunction

   // Sign-extend a product to the accumulator width.
   function automatic sum_t sext_prod(input prod_t p);
      return {{(SUM_W-PROD_W){p[PROD_W-1]}}, p};
   endfunction

endpackage

// File: rtl/tap_comb_fifo2.sv
// Two-entry result FIFO. A push into a full FIFO is accepted only when a
// pop happens in the same cycle; otherwise it is dropped and flagged.
module tap_comb_fifo2
   import tap_comb_pkg::*;
#(
   parameter type T = logic [7:0]
) (
   input  logic clk,
   input  logic rst,
   input  logic i_push,
   input  T     i_data,
   input  logic i_pop,
   output T     o_data,
   output logic o_valid,
   output logic o_drop
);

   localparam logic [1:0] CNT_FULL = 2'(FIFO_DEPTH);

   T           r_mem [0:1];
   logic       r_wr;
   logic       r_rd;
   logic [1:0] r_count;

   logic       w_full;
   logic       w_pop;
   logic       w_push;

   // Decide which of push/pop actually take effect this cycle.
   always_comb begin
      w_full  = (r_count == CNT_FULL);
      w_pop   = i_pop && (r_count != 2'd0);
      w_push  = i_push && (!w_full || w_pop);
      o_drop  = i_push && w_full && !w_pop;
      o_valid = (r_count != 2'd0);
      o_data  = r_mem[r_rd];
   end

   // Storage, pointers and occupancy; when full, a simultaneous push
   // overwrites exactly the slot being popped.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr     <= 1'b0;
         r_rd     <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= i_data;
            r_wr        <= ~r_wr;
         end else begin
            r_wr        <= r_wr;
         end
         if (w_pop) begin
            r_rd <= ~r_rd;
         end else begin
            r_rd <= r_rd;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/tap_combiner_8x4.sv
// Weighted sum of four taps of an upstream 8x64 shift register. Samples
// once per shift after the register has filled, multiplies in stage 1,
// adds in stage 2 (the FIFO storage acts as the stage-2 register) and
// hands results downstream through a 2-entry FIFO.
module tap_combiner_8x4
   import tap_comb_pkg::*;
#(
   parameter logic signed [COEF_W-1:0] C0 = 8'sd1,
   parameter logic signed [COEF_W-1:0] C1 = 8'sd2,
   parameter logic signed [COEF_W-1:0] C2 = 8'sd2,
   parameter logic signed [COEF_W-1:0] C3 = 8'sd1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             shift,
   input  logic [TAP_W-1:0] tap_one,
   input  logic [TAP_W-1:0] tap_two,
   input  logic [TAP_W-1:0] tap_three,
   input  logic [TAP_W-1:0] tap_out,
   input  logic             ovf_clr,
   output sum_t             out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             ovf,
   output logic [CNT_W-1:0] result_cnt
);

   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(FILL_DEPTH);

   logic [FILL_W-1:0] r_fill;
   logic              r_shift_d;
   logic              r_s1_valid;
   prod_t             r_prod [0:3];
   logic              r_ovf;
   logic [CNT_W-1:0]  r_result_cnt;

   logic              w_sample;
   sum_t              w_sum;
   logic              w_pop;
   logic              w_drop;

   // Sample only in the cycle right after a shift once the register is full.
   always_comb begin
      w_sample = r_shift_d && (r_fill == FILL_MAX);
      w_sum    = sext_prod(r_prod[0]) + sext_prod(r_prod[1])
               + sext_prod(r_prod[2]) + sext_prod(r_prod[3]);
      w_pop    = out_valid && out_ready;
   end

   // Track shifts (saturating) and delay the shift strobe by one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fill    <= '0;
         r_shift_d <= 1'b0;
      end else begin
         r_shift_d <= shift;
         if (shift && (r_fill != FILL_MAX)) begin
            r_fill <= r_fill + 7'd1;
         end else begin
            r_fill <= r_fill;
         end
      end
   end

   // Stage 1: register the four weighted taps on a sampling cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            r_prod[i] <= '0;
         end
      end else begin
         r_s1_valid <= w_sample;
         if (w_sample) begin
            r_prod[0] <= tap_mul(tap_one,   C0);
            r_prod[1] <= tap_mul(tap_two,   C1);
            r_prod[2] <= tap_mul(tap_three, C2);
            r_prod[3] <= tap_mul(tap_out,   C3);
         end else begin
            for (int i = 0; i < 4; i++) begin
               r_prod[i] <= r_prod[i];
            end
         end
      end
   end

   tap_comb_fifo2 #(
      .T (sum_t)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (r_s1_valid),
      .i_data  (w_sum),
      .i_pop   (w_pop),
      .o_data  (out_data),
      .o_valid (out_valid),
      .o_drop  (w_drop)
   );

   // Sticky overflow: a new drop wins over a clear in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (w_drop) begin
         r_ovf <= 1'b1;
      end else if (ovf_clr) begin
         r_ovf <= 1'b0;
      end else begin
         r_ovf <= r_ovf;
      end
   end

   // Count results accepted downstream, wrapping naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_result_cnt <= '0;
      end else if (w_pop) begin
         r_result_cnt <= r_result_cnt + 16'd1;
      end else begin
         r_result_cnt <= r_result_cnt;
      end
   end

   assign ovf        = r_ovf;
   assign result_cnt = r_result_cnt;

endmodule

// File: tb/tb_tap_combiner_8x4.sv
// Scoreboard bench: three instances (default, all -128, all 127
// coefficients) share one stimulus stream; expected sums are queued when
// the sampling cycle is driven and compared when the FIFO head is shown.
module tb_tap_combiner_8x4;
   import tap_comb_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       shift;
   logic       ovf_clr;
   logic       out_ready;
   logic [7:0] tap_one, tap_two, tap_three, tap_out;

   sum_t        d0, d1, d2;
   logic        v0, v1, v2;
   logic        f0, f1, f2;
   logic [15:0] c0, c1, c2;

   tap_combiner_8x4 u0 (
      .clk(clk), .rst(rst), .shift(shift), .tap_one(tap_one), .tap_two(tap_two),
      .tap_three(tap_three), .tap_out(tap_out), .ovf_clr(ovf_clr), .out_data(d0),
      .out_valid(v0), .out_ready(out_ready), .ovf(f0), .result_cnt(c0));

   tap_combiner_8x4 #(.C0(8'sh80), .C1(8'sh80), .C2(8'sh80), .C3(8'sh80)) u1 (
      .clk(clk), .rst(rst), .shift(shift), .tap_one(tap_one), .tap_two(tap_two),
      .tap_three(tap_three), .tap_out(tap_out), .ovf_clr(ovf_clr), .out_data(d1),
      .out_valid(v1), .out_ready(out_ready), .ovf(f1), .result_cnt(c1));

   tap_combiner_8x4 #(.C0(8'sh7f), .C1(8'sh7f), .C2(8'sh7f), .C3(8'sh7f)) u2 (
      .clk(clk), .rst(rst), .shift(shift), .tap_one(tap_one), .tap_two(tap_two),
      .tap_three(tap_three), .tap_out(tap_out), .ovf_clr(ovf_clr), .out_data(d2),
      .out_valid(v2), .out_ready(out_ready), .ovf(f2), .result_cnt(c2));

   typedef struct {
      longint e0;
      longint e1;
      longint e2;
   } exp_t;

   exp_t   sb_q[$];
   int     n_checks = 0;
   int     n_pass   = 0;
   int     mfill;
   bit     prev_sh;
   longint mcnt;
   longint cnt_before;

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   function automatic longint wsum(input longint k0, input longint k1, input longint k2,
                                   input longint k3, input longint a, input longint b,
                                   input longint c, input longint d);
      return k0 * a + k1 * b + k2 * c + k3 * d;
   endfunction

   // One clock of stimulus. Taps driven in the cycle after a shift are the
   // ones sampled; keep=0 marks a sample the bench expects to be dropped.
   task automatic drive_cycle(input bit sh, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d, input bit keep);
      exp_t e;
      @(posedge clk); #1;
      if (prev_sh && mfill == 64 && keep) begin
         e.e0 = wsum(1, 2, 2, 1, a, b, c, d);
         e.e1 = wsum(-128, -128, -128, -128, a, b, c, d);
         e.e2 = wsum(127, 127, 127, 127, a, b, c, d);
         sb_q.push_back(e);
         mcnt++;
      end
      shift     = sh;
      tap_one   = a;
      tap_two   = b;
      tap_three = c;
      tap_out   = d;
      if (sh && mfill < 64) mfill++;
      prev_sh = sh;
   endtask

   task automatic idle(input int n);
      repeat (n) drive_cycle(1'b0, tap_one, tap_two, tap_three, tap_out, 1'b1);
   endtask

   task automatic apply_reset(input int n);
      @(posedge clk); #1;
      rst = 1'b1; shift = 1'b0; prev_sh = 1'b0; mfill = 0; mcnt = 0;
      sb_q.delete();
      repeat (n) @(posedge clk);
      @(negedge clk);
      check("rst_valid", {v0, v1, v2}, 0);
      check("rst_data", d0, 0);
      check("rst_ovf", {f0, f1, f2}, 0);
      check("rst_cnt", c0, 0);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // 63 shifts give nothing; the 64th (cycle k) gives out_valid in k+3.
   task automatic fill_check(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d);
      for (int i = 0; i < 63; i++) begin
         drive_cycle(1'b1, a, b, c, d, 1'b1);
         @(negedge clk); check("prefill_valid", v0, 0);
      end
      for (int i = 0; i < 5; i++) begin
         drive_cycle(1'b0, a, b, c, d, 1'b1);
         @(negedge clk); check("prefill_idle_valid", v0, 0);
      end
      drive_cycle(1'b1, a, b, c, d, 1'b1);
      @(negedge clk); check("lat_k", v0, 0);
      drive_cycle(1'b0, a, b, c, d, 1'b1);
      @(negedge clk); check("lat_k1", v0, 0);
      drive_cycle(1'b0, a, b, c, d, 1'b1);
      @(negedge clk); check("lat_k2", v0, 0);
      drive_cycle(1'b0, a, b, c, d, 1'b1);
      @(negedge clk); check("lat_k3", v0, 1);
   endtask

   // Compare the FIFO head against the scoreboard; retire it on a pop.
   always @(negedge clk) begin
      if (!rst && (v0 || v1 || v2)) begin
         check("valid_agree", {v0, v1, v2}, 3'b111);
         if (sb_q.size() == 0) begin
            check("unexpected_valid", v0, 0);
         end else begin
            check("data_c_default", d0, sb_q[0].e0);
            check("data_c_min", d1, sb_q[0].e1);
            check("data_c_max", d2, sb_q[0].e2);
            if (out_ready) void'(sb_q.pop_front());
         end
      end
   end

   initial begin
      rst = 1'b1; shift = 1'b0; ovf_clr = 1'b0; out_ready = 1'b1;
      tap_one = 8'd0; tap_two = 8'd0; tap_three = 8'd0; tap_out = 8'd0;
      mfill = 0; prev_sh = 1'b0; mcnt = 0; cnt_before = 0;

      apply_reset(3);

      // Fill, first-sample latency and the default-coefficient sum.
      fill_check(8'd10, 8'd20, 8'd30, 8'd40);
      check("sum_150", d0, 150);
      idle(2);

      // Coefficient extremes with all taps at 255.
      drive_cycle(1'b1, 8'd255, 8'd255, 8'd255, 8'd255, 1'b1);
      idle(3);
      @(negedge clk);
      check("min_coef_sum", d1, -130560);
      check("max_coef_sum", d2, 129540);
      idle(2);

      // Back-to-back shifts with random taps: one result per shift.
      for (int i = 0; i < 8; i++) begin
         drive_cycle(1'b1, 8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)),
                     8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)), 1'b1);
      end
      drive_cycle(1'b0, 8'd7, 8'd9, 8'd11, 8'd13, 1'b1);
      idle(4);
      @(negedge clk);
      check("b2b_cnt", c0, mcnt);
      check("b2b_queue_empty", sb_q.size(), 0);

      // Overflow: three samples with no downstream acceptance.
      idle(1); out_ready = 1'b0;
      drive_cycle(1'b1, 8'd11, 8'd22, 8'd33, 8'd44, 1'b1);
      drive_cycle(1'b1, 8'd55, 8'd66, 8'd77, 8'd88, 1'b1);
      drive_cycle(1'b1, 8'd1, 8'd2, 8'd3, 8'd4, 1'b1);
      drive_cycle(1'b0, 8'd9, 8'd8, 8'd7, 8'd6, 1'b0);
      idle(4);
      @(negedge clk);
      check("ovf_set", {f0, f1, f2}, 3'b111);
      check("held_valid", v0, 1);
      check("held_count", sb_q.size(), 2);
      check("held_data", d0, wsum(1, 2, 2, 1, 55, 66, 77, 88));
      idle(3);
      @(negedge clk);
      check("held_data_later", d0, wsum(1, 2, 2, 1, 55, 66, 77, 88));
      idle(1); ovf_clr = 1'b1;
      idle(1); ovf_clr = 1'b0;
      @(negedge clk);
      check("ovf_cleared", f0, 0);

      // Clear and a fresh drop in the same cycle: the drop wins.
      drive_cycle(1'b1, 8'd5, 8'd5, 8'd5, 8'd5, 1'b1);
      drive_cycle(1'b0, 8'd6, 8'd6, 8'd6, 8'd6, 1'b0);
      idle(1); ovf_clr = 1'b1;
      idle(1); ovf_clr = 1'b0;
      @(negedge clk);
      check("ovf_clr_collide", f0, 1);
      idle(1); ovf_clr = 1'b1;
      idle(1); ovf_clr = 1'b0;
      @(negedge clk);
      check("ovf_recleared", f0, 0);
      idle(1); out_ready = 1'b1;
      idle(4);
      @(negedge clk);
      check("ovf_drain_cnt", c0, mcnt);
      check("ovf_drain_empty", sb_q.size(), 0);

      // Full FIFO, pop and push in the same cycle: nothing dropped.
      idle(1); out_ready = 1'b0;
      drive_cycle(1'b1, 8'd3, 8'd5, 8'd7, 8'd9, 1'b1);
      drive_cycle(1'b1, 8'd2, 8'd4, 8'd6, 8'd8, 1'b1);
      drive_cycle(1'b0, 8'd100, 8'd0, 8'd0, 8'd200, 1'b1);
      idle(3);
      @(negedge clk);
      check("full_valid", v0, 1);
      drive_cycle(1'b1, 8'd1, 8'd1, 8'd1, 8'd1, 1'b1);
      drive_cycle(1'b0, 8'd40, 8'd30, 8'd20, 8'd10, 1'b1);
      cnt_before = mcnt - 3;
      idle(1); out_ready = 1'b1;
      idle(1); out_ready = 1'b0;
      @(negedge clk);
      check("simul_ovf", {f0, f1, f2}, 0);
      check("simul_cnt", c0, cnt_before + 1);
      check("simul_count", sb_q.size(), 2);
      idle(1); out_ready = 1'b1;
      idle(4);
      @(negedge clk);
      check("simul_drain_cnt", c0, mcnt);

      // Reset one cycle after a shift with a result in flight.
      drive_cycle(1'b1, 8'd50, 8'd60, 8'd70, 8'd80, 1'b1);
      apply_reset(2);
      for (int i = 0; i < 6; i++) begin
         idle(1);
         @(negedge clk);
         check("post_rst_valid", v0, 0);
         check("post_rst_cnt", c0, 0);
      end
      fill_check(8'd1, 8'd2, 8'd3, 8'd4);
      idle(4);
      @(negedge clk);
      check("final_cnt", c0, mcnt);
      check("final_cnt_agree", {c1, c2}, {c0, c0});
      check("final_queue_empty", sb_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/tap_combiner_8x4.md
TAP_COMBINER_8X4 -- requirements
Module: tap_combiner_8x4

Interface
REQ-001 Parameter C0, default 1, signed 8-bit coefficient applied to tap_one.
REQ-002 Parameter C1, default 2, signed 8-bit coefficient applied to tap_two.
REQ-003 Parameter C2, default 2, signed 8-bit coefficient applied to tap_three.
REQ-004 Parameter C3, default 1, signed 8-bit coefficient applied to tap_out.
REQ-005 clk  input  1  single clock; all state on posedge clk.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 shift  input  1  the upstream 8x64 shift register's shift strobe, one cycle per shift.
REQ-008 tap_one, tap_two, tap_three, tap_out  input  8 each  upstream stages 15, 31, 47 and 63, unsigned.
REQ-009 ovf_clr  input  1  clears the sticky overflow flag.
REQ-010 out_data  output  18  signed weighted tap sum.
REQ-011 out_valid  output  1  out_data holds a valid result.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 ovf  output  1  sticky flag: a result was dropped.
REQ-014 result_cnt  output  16  count of accepted results, wraps modulo 2^16.

Function
REQ-015 The block SHALL keep a fill counter that increments on each cycle with shift=1 and saturates at 64.
REQ-016 Sampling SHALL occur in the cycle after a shift cycle (shift_d=1), and only if the fill counter equals 64 in that cycle; the first sample follows the 64th shift.
REQ-017 On a sampling cycle, stage 1 SHALL register the four signed 16-bit products: zero-extended tap times coefficient.
REQ-018 Stage 2 SHALL register the 18-bit signed sum of the four products; no saturation is needed, since every coefficient value fits.
REQ-019 Latency: shift high in cycle k gives out_valid high in cycle k+3, when the FIFO is empty and the fill counter is saturated.
REQ-020 Stage 2 results SHALL be pushed into a 2-entry FIFO; out_data/out_valid reflect the FIFO head.
REQ-021 A pop SHALL occur when out_valid && out_ready; result_cnt increments by 1 on each pop.
REQ-022 Push and pop in the same cycle SHALL both succeed when the FIFO is full.
REQ-023 Push while full with no pop SHALL drop the new result, leave the FIFO unchanged and set ovf.
REQ-024 ovf SHALL stay set until ovf_clr=1 or rst=1.
REQ-025 If ovf_clr and a new overflow occur in the same cycle, ovf SHALL end up 1.
REQ-026 out_data SHALL hold its value while out_valid && !out_ready.
REQ-027 Back-to-back shift cycles SHALL each produce one result; the pipeline never stalls.

Reset
REQ-028 While rst=1, the fill counter, shift_d, pipeline valid bits, FIFO pointers/count, ovf and result_cnt SHALL be cleared to 0.
REQ-029 During reset, out_valid=0 and out_data=0.
REQ-030 A rst asserted mid-pipeline SHALL discard all in-flight results.
REQ-031 After rst, 64 new shifts SHALL be required before sampling resumes.

Structure
REQ-032 Package tap_comb_pkg SHALL hold TAP_W=8, PROD_W=16, SUM_W=18, FILL_DEPTH=64, FIFO_DEPTH=2 and typedef sum_t (signed [17:0]).
REQ-033 The 2-entry FIFO SHALL be sub-module tap_comb_fifo2, parameterised by data type.
REQ-034 The full implementation SHALL fit in 120-400 lines.

Verification
REQ-035 Scenario: after rst, 63 shifts -> out_valid never rises; the 64th shift in cycle k -> out_valid in cycle k+3.
REQ-036 Scenario: default coefficients, taps 10/20/30/40 -> out_data = 10+40+60+40 = 150.
REQ-037 Scenario: C0..C3=-128, all taps 255 -> out_data = -130560; with C0..C3=127 -> out_data = 129540.
REQ-038 Scenario: out_ready=0 and 3 samples -> first two results held in order, third dropped, ovf=1; ovf_clr -> ovf=0.
REQ-039 Scenario: full FIFO, out_ready=1 with a simultaneous push -> no drop, ovf stays 0, result_cnt increments by 1.
REQ-040 Scenario: rst asserted one cycle after a shift with a result in flight -> no out_valid afterwards; fill counter and result_cnt = 0.
